// File: rtl/rd_burst_scheduler_if.sv
// Signal bundle between the kernel control, the AXI AR channel and the R-channel
// last-beat detector for one rd_burst_scheduler.
interface rd_burst_scheduler_if #(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_LEN_WIDTH  = 32
);
  logic                    ctrl_start;
  logic [C_ADDR_WIDTH-1:0] ctrl_addr;
  logic [C_LEN_WIDTH-1:0]  ctrl_num_beats;
  logic                    ctrl_busy;
  logic                    ctrl_done;

  // AR handshake: a transfer occurs on every rising edge where m_arvalid and
  // m_arready are both high; once raised, m_arvalid/m_araddr/m_arlen hold until then.
  logic                    m_arvalid;
  logic                    m_arready;
  logic [C_ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]              m_arlen;

  logic                    burst_done;

  modport master (
    input  ctrl_start, ctrl_addr, ctrl_num_beats, m_arready, burst_done,
    output ctrl_busy, ctrl_done, m_arvalid, m_araddr, m_arlen
  );

  modport slave (
    output ctrl_start, ctrl_addr, ctrl_num_beats, m_arready, burst_done,
    input  ctrl_busy, ctrl_done, m_arvalid, m_araddr, m_arlen
  );
endinterface

// File: rtl/rd_burst_scheduler.sv
// Splits one read request into AR bursts of at most C_BURST_LEN beats, with a
// credit counter bounding the bursts in flight, and pulses done when all return.
module rd_burst_scheduler #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_LEN_WIDTH       = 32,
  parameter int C_DATA_BYTES      = 64,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  rd_burst_scheduler_if.master                   bus,
  output logic [1:0]                             o_dbg_state,
  output logic [$clog2(C_MAX_OUTSTANDING):0]     o_dbg_outstanding
);

  localparam int OW = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam logic [C_LEN_WIDTH-1:0]  LP_BURST  = C_LEN_WIDTH'(C_BURST_LEN);
  localparam logic [C_ADDR_WIDTH-1:0] LP_STRIDE = C_ADDR_WIDTH'(C_BURST_LEN * C_DATA_BYTES);
  localparam logic [OW-1:0]           LP_MAX    = OW'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [C_LEN_WIDTH-1:0]  r_remaining;
  logic [C_LEN_WIDTH-1:0]  w_len;
  logic [C_LEN_WIDTH-1:0]  w_len_m1;
  logic [OW-1:0]           r_outstanding;
  logic [OW-1:0]           w_out_next;
  logic                    w_arvalid;
  logic                    w_ar_hs;
  logic                    w_bd;
  logic                    w_accept;

  assign w_len    = (r_remaining < LP_BURST) ? r_remaining : LP_BURST;
  assign w_len_m1 = w_len - C_LEN_WIDTH'(1);
  assign w_accept = (r_state == S_IDLE) && bus.ctrl_start && (bus.ctrl_num_beats != '0);

  // Credit is judged on the registered count, so a pending request can only gain credit.
  assign w_arvalid = (r_state == S_ISSUE) && (r_remaining != '0) && (r_outstanding < LP_MAX);
  assign w_ar_hs   = w_arvalid && bus.m_arready;
  assign w_bd      = bus.burst_done && ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                     && (r_outstanding != '0);

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_ar_hs, w_bd})
      2'b10:   w_out_next = r_outstanding + OW'(1);
      2'b01:   w_out_next = r_outstanding - OW'(1);
      default: w_out_next = r_outstanding;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_start) begin
          w_next = (bus.ctrl_num_beats == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_ar_hs && (r_remaining == w_len)) begin
          w_next = S_DRAIN;
        end
      end
      // The final burst_done and the move to DONE share one edge.
      S_DRAIN: begin
        if (w_out_next == '0) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_accept) begin
        r_addr      <= bus.ctrl_addr;
        r_remaining <= bus.ctrl_num_beats;
      end else if (w_ar_hs) begin
        r_addr      <= r_addr + LP_STRIDE;
        r_remaining <= r_remaining - w_len;
      end
    end
  end

  assign bus.ctrl_busy  = (r_state != S_IDLE);
  assign bus.ctrl_done  = (r_state == S_DONE);
  assign bus.m_arvalid  = w_arvalid;
  assign bus.m_araddr   = r_addr;
  assign bus.m_arlen    = (r_state == S_ISSUE) ? w_len_m1[7:0] : 8'd0;

  assign o_dbg_state       = r_state;
  assign o_dbg_outstanding = r_outstanding;

endmodule

// File: tb/tb_rd_burst_scheduler.sv
// Directed bench for rd_burst_scheduler: a 16-credit instance for the transfer
// tests and a 2-credit instance for the credit-limit and mid-transfer reset tests.
module tb_rd_burst_scheduler;

  localparam int BD_DELAY = 10;

  logic clk;
  logic rst;

  rd_burst_scheduler_if #(.C_ADDR_WIDTH(64), .C_LEN_WIDTH(32)) bus ();
  rd_burst_scheduler_if #(.C_ADDR_WIDTH(64), .C_LEN_WIDTH(32)) bus_c ();

  logic [1:0] dbg_state;
  logic [4:0] dbg_out;
  logic [1:0] dbg_state_c;
  logic [1:0] dbg_out_c;

  rd_burst_scheduler #(.C_MAX_OUTSTANDING(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .o_dbg_state       (dbg_state),
    .o_dbg_outstanding (dbg_out)
  );

  rd_burst_scheduler #(.C_MAX_OUTSTANDING(2)) dut_c (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus_c),
    .o_dbg_state       (dbg_state_c),
    .o_dbg_outstanding (dbg_out_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [71:0] exp_q[$];
  int          due_q[$];
  int          ar_cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_ar = 0;
  int          done_seen = 0;
  int          done_cyc = -1;
  bit          bd_auto = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: monitor the main AR channel at negedge, then advance and drive auto burst_done.
  task automatic tick();
    logic [71:0] e;
    @(negedge clk);
    if (bus.m_arvalid && bus.m_arready) begin
      n_ar++;
      ar_cyc_q.push_back(cyc);
      check("ar_avail", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ar_addr_len", {bus.m_araddr, bus.m_arlen}, e);
      end
      if (bd_auto) due_q.push_back(cyc + BD_DELAY);
    end
    if (bus.ctrl_done) begin
      done_seen++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.burst_done = 1'b0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      bus.burst_done = 1'b1;
      void'(due_q.pop_front());
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Drives a one-cycle start; returns the cycle in which start was high.
  task automatic start_xfer(input logic [63:0] addr, input logic [31:0] nb, output int s);
    bus.ctrl_start     = 1'b1;
    bus.ctrl_addr      = addr;
    bus.ctrl_num_beats = nb;
    s = cyc;
    tick();
    bus.ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < budget && done_seen == d0; i++) tick();
    check({tag, "_done_once"}, 128'(done_seen - d0), 128'd1);
  endtask

  function automatic int first_ar();
    return (ar_cyc_q.size() > 0) ? ar_cyc_q[0] : -1;
  endfunction

  function automatic int last_ar();
    return (ar_cyc_q.size() > 0) ? ar_cyc_q[ar_cyc_q.size()-1] : -1;
  endfunction

  initial begin
    int s;
    int hs_c;
    rst = 1'b1;
    bus.ctrl_start = 1'b0;     bus.ctrl_addr = '0;    bus.ctrl_num_beats = '0;
    bus.m_arready = 1'b1;      bus.burst_done = 1'b0;
    bus_c.ctrl_start = 1'b0;   bus_c.ctrl_addr = '0;  bus_c.ctrl_num_beats = '0;
    bus_c.m_arready = 1'b1;    bus_c.burst_done = 1'b0;

    // reset values
    tick(); tick();
    check("rst_busy",    bus.ctrl_busy, 0);
    check("rst_done",    bus.ctrl_done, 0);
    check("rst_arvalid", bus.m_arvalid, 0);
    check("rst_araddr",  bus.m_araddr, 0);
    check("rst_arlen",   bus.m_arlen, 0);
    check("rst_state",   dbg_state, 0);
    check("rst_outst",   dbg_out, 0);
    rst = 1'b0;
    tick();

    // full bursts: 256 beats -> 4 x 64
    exp_q = {};
    ar_cyc_q = {};
    exp_q.push_back({64'h0000_0001_0000_0000, 8'd63});
    exp_q.push_back({64'h0000_0001_0000_1000, 8'd63});
    exp_q.push_back({64'h0000_0001_0000_2000, 8'd63});
    exp_q.push_back({64'h0000_0001_0000_3000, 8'd63});
    start_xfer(64'h0000_0001_0000_0000, 32'd256, s);
    settle();
    check("t1_busy_t1",    bus.ctrl_busy, 1);
    check("t1_arvalid_t1", bus.m_arvalid, 1);
    wait_done("t1", 100);
    check("t1_ar_count", ar_cyc_q.size(), 4);
    check("t1_first_ar", first_ar(), s + 1);
    check("t1_last_ar",  last_ar(),  s + 4);
    check("t1_done_cyc", done_cyc,   s + 15);
    settle();
    check("t1_done_pulse", bus.ctrl_done, 0);
    check("t1_busy_after", bus.ctrl_busy, 0);
    check("t1_exp_empty",  exp_q.size(), 0);

    // remainder: 130 beats -> 64, 64, 2
    ar_cyc_q = {};
    exp_q.push_back({64'h2000, 8'd63});
    exp_q.push_back({64'h3000, 8'd63});
    exp_q.push_back({64'h4000, 8'd1});
    tick();
    start_xfer(64'h2000, 32'd130, s);
    wait_done("t2", 100);
    check("t2_ar_count", ar_cyc_q.size(), 3);
    check("t2_done_cyc", done_cyc, s + 14);

    // zero-beat request
    ar_cyc_q = {};
    tick();
    start_xfer(64'h9000, 32'd0, s);
    settle();
    check("t3_done_t1",    bus.ctrl_done, 1);
    check("t3_busy_t1",    bus.ctrl_busy, 1);
    check("t3_arvalid_t1", bus.m_arvalid, 0);
    tick();
    settle();
    check("t3_done_t2",  bus.ctrl_done, 0);
    check("t3_state_t2", dbg_state, 0);
    check("t3_no_ar",    ar_cyc_q.size(), 0);

    // backpressure with an ignored start mid-stall
    ar_cyc_q = {};
    exp_q.push_back({64'h10000, 8'd63});
    exp_q.push_back({64'h11000, 8'd63});
    bus.m_arready = 1'b0;
    tick();
    start_xfer(64'h10000, 32'd128, s);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      bus.ctrl_start = 1'b0;
      settle();
      check("t4_hold_valid", bus.m_arvalid, 1);
      check("t4_hold_addr",  bus.m_araddr, 64'h10000);
      check("t4_hold_len",   bus.m_arlen, 63);
      if (i == 3) begin
        bus.ctrl_start     = 1'b1;
        bus.ctrl_addr      = 64'hDEAD_0000;
        bus.ctrl_num_beats = 32'd0;
      end
    end
    bus.m_arready = 1'b1;
    wait_done("t4", 100);
    check("t4_done_cyc", done_cyc, s + 17);
    check("t4_exp_empty", exp_q.size(), 0);

    // simultaneous handshake and burst_done
    bd_auto = 1'b0;
    exp_q.push_back({64'h40000, 8'd63});
    exp_q.push_back({64'h41000, 8'd63});
    exp_q.push_back({64'h42000, 8'd63});
    tick();
    start_xfer(64'h40000, 32'd192, s);
    tick();
    bus.m_arready = 1'b0;
    settle();
    check("t5_outst_1", dbg_out, 1);
    tick();
    bus.m_arready = 1'b1;
    bus.burst_done = 1'b1;
    settle();
    check("t5_hs_valid", bus.m_arvalid, 1);
    tick();
    bus.m_arready = 1'b0;
    settle();
    check("t5_outst_same", dbg_out, 1);
    check("t5_addr_next",  bus.m_araddr, 64'h42000);
    tick();
    bus.m_arready = 1'b1;
    tick();
    bus.burst_done = 1'b1;
    settle();
    check("t5_drain_state", dbg_state, 2);
    check("t5_drain_outst", dbg_out, 2);
    tick();
    bus.burst_done = 1'b1;
    settle();
    check("t5_outst_dec", dbg_out, 1);
    tick();
    settle();
    check("t5_done",       bus.ctrl_done, 1);
    check("t5_outst_zero", dbg_out, 0);
    tick();
    bd_auto = 1'b1;

    // credit limit on the 2-credit instance
    hs_c = 0;
    bus_c.ctrl_start     = 1'b1;
    bus_c.ctrl_addr      = 64'h80000;
    bus_c.ctrl_num_beats = 32'd640;
    tick();
    bus_c.ctrl_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      settle();
      if (bus_c.m_arvalid && bus_c.m_arready) hs_c++;
      if (i == 2) check("t6_addr_2nd", bus_c.m_araddr, 64'h81000);
      if (i == 3) check("t6_stall", bus_c.m_arvalid, 0);
    end
    check("t6_ar_count", hs_c, 2);
    bus_c.burst_done = 1'b1;
    tick();
    bus_c.burst_done = 1'b0;
    settle();
    check("t6_reenable", bus_c.m_arvalid, 1);
    check("t6_addr_3rd", bus_c.m_araddr, 64'h82000);

    // reset mid-ISSUE
    rst = 1'b1;
    tick();
    settle();
    check("t7_busy",    bus_c.ctrl_busy, 0);
    check("t7_arvalid", bus_c.m_arvalid, 0);
    check("t7_araddr",  bus_c.m_araddr, 0);
    check("t7_arlen",   bus_c.m_arlen, 0);
    check("t7_outst",   dbg_out_c, 0);
    check("t7_state",   dbg_state_c, 0);
    rst = 1'b0;
    tick();

    // address wrap and single-beat tail
    ar_cyc_q = {};
    exp_q.push_back({64'hFFFF_FFFF_FFFF_F000, 8'd63});
    exp_q.push_back({64'h0, 8'd0});
    start_xfer(64'hFFFF_FFFF_FFFF_F000, 32'd65, s);
    wait_done("t8", 100);
    check("t8_ar_count", ar_cyc_q.size(), 2);
    check("t8_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
